// File: rtl/ap_share_server.sv
// Ping-pong store for seven-entry sets of 30-bit approximation shares.
// A serial producer fills one bank while the reader is served from the other.
module ap_share_server (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [29:0] in_data,
    output logic        in_ready,
    output logic        start,
    input  logic [2:0]  rd_addr,
    output logic [29:0] ap_shares,
    output logic        err
);
    localparam int NSHARE = 7;
    localparam int W      = 30;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    logic [W-1:0] bank0_q [NSHARE];
    logic [W-1:0] bank1_q [NSHARE];
    logic [1:0]   full_q, full_d;
    logic         wr_sel_q;
    logic [2:0]   wr_idx_q;
    logic         rd_sel_q;
    logic [2:0]   cnt_q;
    state_t       state_q;
    logic         start_q;
    logic [W-1:0] ap_shares_q;
    logic         err_q;

    logic         accept_s;
    logic         wr_done_s;
    logic         rd_done_s;
    logic         rd_sel_n_s;
    logic [W-1:0] rd_word_s;

    assign in_ready   = ~full_q[wr_sel_q];
    assign accept_s   = in_valid & ~full_q[wr_sel_q];
    assign wr_done_s  = accept_s & (wr_idx_q == 3'd6);
    assign rd_done_s  = (state_q == SERVE) & (cnt_q == 3'd6);
    assign rd_sel_n_s = ~rd_sel_q;

    assign start     = start_q;
    assign ap_shares = ap_shares_q;
    assign err       = err_q;

    // Full flags: a completing write and a finishing serve always hit different banks.
    always_comb begin
        full_d = full_q;
        if (wr_done_s) begin
            full_d[wr_sel_q] = 1'b1;
        end else begin
            full_d = full_d;
        end
        if (rd_done_s) begin
            full_d[rd_sel_q] = 1'b0;
        end else begin
            full_d = full_d;
        end
    end

    // Read mux; index 7 is outside the set and reads as zero.
    always_comb begin
        rd_word_s = {W{1'b0}};
        if (rd_addr == 3'd7) begin
            rd_word_s = {W{1'b0}};
        end else if (rd_sel_q) begin
            rd_word_s = bank1_q[rd_addr];
        end else begin
            rd_word_s = bank0_q[rd_addr];
        end
    end

    // Share storage, deliberately left unreset.
    always_ff @(posedge clk) begin
        if (accept_s && wr_sel_q) begin
            bank1_q[wr_idx_q] <= in_data;
        end else if (accept_s) begin
            bank0_q[wr_idx_q] <= in_data;
        end
    end

    // Write-side pointers and the shared full flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q   <= 2'b00;
            wr_sel_q <= 1'b0;
            wr_idx_q <= 3'd0;
        end else begin
            full_q <= full_d;
            if (wr_done_s) begin
                wr_sel_q <= ~wr_sel_q;
                wr_idx_q <= 3'd0;
            end else if (accept_s) begin
                wr_idx_q <= wr_idx_q + 3'd1;
            end
        end
    end

    // Serve FSM with registered start, output word and sticky lockstep error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            cnt_q       <= 3'd0;
            rd_sel_q    <= 1'b0;
            ap_shares_q <= {W{1'b0}};
            err_q       <= 1'b0;
        end else begin
            ap_shares_q <= rd_word_s;
            err_q       <= err_q | (start_q & (rd_addr != cnt_q));
            case (state_q)
                IDLE: begin
                    cnt_q <= 3'd0;
                    if (full_q[rd_sel_q]) begin
                        state_q <= SERVE;
                        start_q <= 1'b1;
                    end
                end
                SERVE: begin
                    if (cnt_q == 3'd6) begin
                        cnt_q    <= 3'd0;
                        rd_sel_q <= rd_sel_n_s;
                        if (full_q[rd_sel_n_s]) begin
                            state_q <= SERVE;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            start_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    start_q <= 1'b0;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ap_share_server.sv
// Directed and randomized bench for ap_share_server against a set-counting reference model.
module tb_ap_share_server;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [29:0] in_data = 30'd0;
    logic        in_ready;
    logic        start;
    logic [2:0]  rd_addr = 3'd0;
    logic [29:0] ap_shares;
    logic        err;

    always #5 clk = ~clk;

    ap_share_server dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .start(start), .rd_addr(rd_addr),
        .ap_shares(ap_shares), .err(err)
    );

    int total = 0;
    int bad = 0;

    // Reference model: banks addressed by how many sets were completed / served.
    logic [29:0] mem [2][7];
    int          done_cnt, served_cnt, wr_pos, m_pos, cyc;
    logic        m_serving, m_err;
    logic [29:0] m_ap;
    int          first_start, last_start, start_cnt, nr_cnt, nr_cyc;

    function automatic logic m_ready();
        return (done_cnt - served_cnt) < 2;
    endfunction

    function automatic logic [2:0] rd();
        int p;
        p = m_serving ? m_pos : 0;
        return p[2:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [29:0] d, input logic [2:0] a);
        logic        acc, nxt_err;
        logic [29:0] nxt_ap;
        int          held;
        in_valid = v;
        in_data  = d;
        rd_addr  = a;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
        if (in_ready === 1'b0) begin
            nr_cnt++;
            nr_cyc = cyc;
        end
        acc     = v && m_ready();
        nxt_ap  = (a == 3'd7) ? 30'd0 : mem[served_cnt % 2][a];
        nxt_err = m_err | (m_serving && (int'(a) != m_pos));
        held    = done_cnt - served_cnt;
        if (!m_serving) begin
            if (held > 0) begin
                m_serving = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos < 6) begin
            m_pos++;
        end else begin
            served_cnt++;
            m_pos = 0;
            m_serving = (held > 1);
        end
        if (acc) begin
            mem[done_cnt % 2][wr_pos] = d;
            if (wr_pos == 6) begin
                done_cnt++;
                wr_pos = 0;
            end else begin
                wr_pos++;
            end
        end
        m_ap  = nxt_ap;
        m_err = nxt_err;
        @(posedge clk);
        #1;
        cyc++;
        check("start", {31'd0, start}, {31'd0, m_serving});
        check("err", {31'd0, err}, {31'd0, m_err});
        if (!$isunknown(m_ap)) check("ap_shares", {2'd0, ap_shares}, {2'd0, m_ap});
        if (start === 1'b1) begin
            if (first_start < 0) first_start = cyc;
            last_start = cyc;
            start_cnt++;
        end
    endtask

    // Mid-cycle reset pulse; called one time unit after a rising edge.
    task automatic do_reset();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_ap", {2'd0, ap_shares}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #1 rst = 1'b0;
        done_cnt = 0; served_cnt = 0; wr_pos = 0; m_pos = 0;
        m_serving = 1'b0; m_err = 1'b0; m_ap = 30'd0;
        cyc = 0; first_start = -1; last_start = -1; start_cnt = 0;
        nr_cnt = 0; nr_cyc = -1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 30'd0, rd());
    endtask

    initial begin
        int  k;
        bit  hit;
        @(posedge clk);
        #1;
        do_reset();

        // Partial set lost across reset
        for (int i = 0; i < 3; i++) step(1'b1, 30'(i + 1), rd());
        do_reset();
        idle(12);
        check("lost_set_no_start", start_cnt, 32'd0);

        // Single set
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 30'(i + 1), rd());
        idle(10);
        check("single_first_start", first_start, 32'd8);
        check("single_last_start", last_start, 32'd14);
        check("single_start_cnt", start_cnt, 32'd7);

        // Two sets back to back
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b1, (i < 7) ? 30'(i + 1) : 30'(i + 4), rd());
        idle(12);
        check("b2b_first_start", first_start, 32'd8);
        check("b2b_last_start", last_start, 32'd21);
        check("b2b_start_cnt", start_cnt, 32'd14);

        // Backpressure with in_valid held high
        do_reset();
        k = 1;
        for (int i = 0; i < 60 && k <= 21; i++) begin
            hit = m_ready();
            step(1'b1, 30'(k), rd());
            if (hit) k++;
        end
        check("bp_all_accepted", k, 32'd22);
        idle(12);
        check("bp_stall_cnt", nr_cnt, 32'd1);
        check("bp_stall_cyc", nr_cyc, 32'd14);
        check("bp_start_cnt", start_cnt, 32'd21);
        check("bp_last_start", last_start, 32'd29);

        // Protocol error: rd_addr=3 while cnt=2
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 30'(100 + i), rd());
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (m_serving && m_pos == 2) begin
                step(1'b0, 30'd0, 3'd3);
                check("perr_err_set", {31'd0, err}, 32'd1);
                check("perr_ap_share3", {2'd0, ap_shares}, 32'd103);
                hit = 1'b1;
            end else begin
                step(1'b0, 30'd0, rd());
            end
        end
        check("perr_reached", {31'd0, hit}, 32'd1);
        idle(12);
        check("perr_sticky", {31'd0, err}, 32'd1);

        // Idle reads of bank 0 (holding 100..106)
        do_reset();
        step(1'b0, 30'd0, 3'd7);
        check("idle_addr7", {2'd0, ap_shares}, 32'd0);
        for (int a = 0; a < 7; a++) begin
            step(1'b0, 30'd0, 3'(a));
            check("idle_read", {2'd0, ap_shares}, 32'(100 + a));
        end
        check("idle_no_err", {31'd0, err}, 32'd0);

        // Randomized traffic with a lockstep reader
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 30'($urandom),
                 m_serving ? rd() : 3'($urandom_range(0, 7)));
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
